// File: rtl/pe_feed_buffer.sv
// pe_feed_buffer: word FIFO feeding one PE input stream (ifmap or filter).
// Host pushes {last, data}; PE pops with read_en and sees dout/valid/end_signal
// one cycle later. No write-to-read bypass; flush clears contents synchronously.
// Build option: define PE_FEED_UNDERFLOW_EN to build the sticky underflow
// detector (read_en while empty); otherwise underflow is tied low.
module pe_feed_buffer #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wr_last,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] count,
  input  logic                 read_en,
  output logic [WIDTH-1:0]     dout,
  output logic                 valid,
  output logic                 end_signal,
  output logic                 underflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(DEPTH);

  logic [WIDTH:0]          mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic                    push;
  logic                    pop;

  // Status flags come straight from the registered occupancy count.
  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign push  = wr_en & ~full;
  assign pop   = read_en & ~empty;

  // Storage array, deliberately without reset; flush blocks the write.
  always_ff @(posedge clk) begin
    if (!flush && push) begin
      mem[wr_ptr] <= {wr_last, wr_data};
    end
  end

  // Pointers and occupancy count; flush overrides push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + ADDR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered read port: single-cycle valid/end strobes, dout holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      valid      <= 1'b0;
      end_signal <= 1'b0;
    end else if (flush) begin
      valid      <= 1'b0;
      end_signal <= 1'b0;
    end else begin
      valid      <= pop;
      end_signal <= pop & mem[rd_ptr][WIDTH];
      if (pop) begin
        dout <= mem[rd_ptr][WIDTH-1:0];
      end
    end
  end

`ifdef PE_FEED_UNDERFLOW_EN
  // Sticky underflow: set on read_en while empty, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow <= 1'b0;
    end else if (read_en && empty) begin
      underflow <= 1'b1;
    end
  end
`else
  assign underflow = 1'b0;
`endif

endmodule
